// File: rtl/apb_i2c_pkg.sv
// ----------------------------------------------------------------------------
// apb_i2c_pkg : register offsets, IRQ bit indices and STATUS field positions
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package apb_i2c_pkg;

   localparam logic [31:0] OFS_TXDATA   = 32'h00;
   localparam logic [31:0] OFS_RXDATA   = 32'h04;
   localparam logic [31:0] OFS_CONFIG   = 32'h08;
   localparam logic [31:0] OFS_TIMEOUT  = 32'h0C;
   localparam logic [31:0] OFS_STATUS   = 32'h10;
   localparam logic [31:0] OFS_IRQ_EN   = 32'h14;
   localparam logic [31:0] OFS_IRQ_STAT = 32'h18;

   localparam int IRQ_TX_EMPTY  = 0;
   localparam int IRQ_RX_NEMPTY = 1;
   localparam int IRQ_TX_OVF    = 2;
   localparam int IRQ_RX_OVF    = 3;
   localparam int IRQ_CORE_ERR  = 4;
   localparam int IRQ_W         = 5;

   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_TX_LVL   = 8;
   localparam int ST_RX_LVL   = 16;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo : show-ahead synchronous FIFO; push when full / pop when empty ignored
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head is forced to zero when empty so stale entries never leak out.
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + 1'b1;
      else if (do_pop && !do_push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

`default_nettype wire

// File: rtl/apb_i2c_csr.sv
// ----------------------------------------------------------------------------
// apb_i2c_csr : APB3 CSR block with TX/RX FIFOs and maskable IRQs for the I2C core
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module apb_i2c_csr
   import apb_i2c_pkg::*;
#(
   parameter int FIFO_W   = 8,
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int CFG_W    = 14,
   parameter int TMO_W    = 14
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSELx,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [31:0]       PADDR,
   input  logic [31:0]       PWDATA,
   output logic [31:0]       PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   input  logic              tx_rd_en,
   output logic [FIFO_W-1:0] tx_rd_data,
   output logic              tx_empty,
   input  logic              rx_wr_en,
   input  logic [FIFO_W-1:0] rx_wr_data,
   output logic              rx_full,
   input  logic              core_error,
   output logic [CFG_W-1:0]  cfg,
   output logic [TMO_W-1:0]  timeout,
   output logic              INT_TX,
   output logic              INT_RX,
   output logic              INT_ERR
);

   logic [$clog2(TX_DEPTH):0] tx_level;
   logic [$clog2(RX_DEPTH):0] rx_level;
   logic [FIFO_W-1:0]         rx_dout;
   logic                      tx_full, rx_empty;

   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [IRQ_W-1:0] irq_en_q, irq_en_d;
   logic [IRQ_W-1:0] stk_q, stk_d;
   logic [IRQ_W-1:0] irq_stat;
   logic             int_tx_q, int_rx_q, int_err_q;

   logic        access, err, wr_ok, rd_ok, tx_push, rx_pop;
   logic [31:0] rdata, status;
   logic        unused_pwdata;

   assign unused_pwdata = ^PWDATA;
   assign access  = PSELx && PENABLE;
   assign PREADY  = access;
   assign PSLVERR = access && err;
   assign PRDATA  = (access && !PWRITE && !err) ? rdata : 32'h0;
   assign wr_ok   = access && PWRITE && !err;
   assign rd_ok   = access && !PWRITE && !err;
   assign tx_push = wr_ok && (PADDR == OFS_TXDATA);
   assign rx_pop  = rd_ok && (PADDR == OFS_RXDATA);

   always_comb begin
      status                          = 32'h0;
      status[ST_TX_EMPTY]             = tx_empty;
      status[ST_TX_FULL]              = tx_full;
      status[ST_RX_EMPTY]             = rx_empty;
      status[ST_RX_FULL]              = rx_full;
      status[ST_TX_LVL +: 8]          = 8'(tx_level);
      status[ST_RX_LVL +: 8]          = 8'(rx_level);
      irq_stat                        = stk_q;
      irq_stat[IRQ_TX_EMPTY]          = tx_empty;
      irq_stat[IRQ_RX_NEMPTY]         = !rx_empty;
   end

   // Decode: misaligned or out-of-range addresses fail, then per-register rules.
   always_comb begin
      err   = (PADDR[1:0] != 2'b00) || (PADDR > OFS_IRQ_STAT);
      rdata = 32'h0;
      case (PADDR)
         OFS_TXDATA:   err = !PWRITE || tx_full;
         OFS_RXDATA:   begin err = PWRITE || rx_empty; rdata = 32'(rx_dout); end
         OFS_CONFIG:   rdata = 32'(cfg_q);
         OFS_TIMEOUT:  rdata = 32'(tmo_q);
         OFS_STATUS:   begin err = PWRITE; rdata = status; end
         OFS_IRQ_EN:   rdata = 32'(irq_en_q);
         OFS_IRQ_STAT: rdata = 32'(irq_stat);
         default:      ;
      endcase
   end

   always_comb begin
      cfg_d    = cfg_q;
      tmo_d    = tmo_q;
      irq_en_d = irq_en_q;
      stk_d    = stk_q;
      if (wr_ok) begin
         case (PADDR)
            OFS_CONFIG:   cfg_d    = PWDATA[CFG_W-1:0];
            OFS_TIMEOUT:  tmo_d    = PWDATA[TMO_W-1:0];
            OFS_IRQ_EN:   irq_en_d = PWDATA[IRQ_W-1:0];
            OFS_IRQ_STAT: stk_d    = stk_q & ~PWDATA[IRQ_W-1:0];
            default:      ;
         endcase
      end
      // Sets are applied after W1C so a same-cycle set wins.
      if (access && PWRITE && (PADDR == OFS_TXDATA) && tx_full) stk_d[IRQ_TX_OVF] = 1'b1;
      if (rx_wr_en && rx_full) stk_d[IRQ_RX_OVF]   = 1'b1;
      if (core_error)          stk_d[IRQ_CORE_ERR] = 1'b1;
      stk_d[IRQ_RX_NEMPTY:IRQ_TX_EMPTY] = 2'b00;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cfg_q     <= '0;
         tmo_q     <= '0;
         irq_en_q  <= '0;
         stk_q     <= '0;
         int_tx_q  <= 1'b0;
         int_rx_q  <= 1'b0;
         int_err_q <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         tmo_q     <= tmo_d;
         irq_en_q  <= irq_en_d;
         stk_q     <= stk_d;
         int_tx_q  <= irq_en_q[IRQ_TX_EMPTY] && irq_stat[IRQ_TX_EMPTY];
         int_rx_q  <= irq_en_q[IRQ_RX_NEMPTY] && irq_stat[IRQ_RX_NEMPTY];
         int_err_q <= |(irq_en_q[IRQ_CORE_ERR:IRQ_TX_OVF] & irq_stat[IRQ_CORE_ERR:IRQ_TX_OVF]);
      end
   end

   assign cfg     = cfg_q;
   assign timeout = tmo_q;
   assign INT_TX  = int_tx_q;
   assign INT_RX  = int_rx_q;
   assign INT_ERR = int_err_q;

   sync_fifo #(.WIDTH(FIFO_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (tx_push),
      .pop   (tx_rd_en),
      .din   (PWDATA[FIFO_W-1:0]),
      .dout  (tx_rd_data),
      .full  (tx_full),
      .empty (tx_empty),
      .level (tx_level)
   );

   sync_fifo #(.WIDTH(FIFO_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .push  (rx_wr_en),
      .pop   (rx_pop),
      .din   (rx_wr_data),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty),
      .level (rx_level)
   );

endmodule

`default_nettype wire

// File: tb/tb_apb_i2c_csr.sv
// ----------------------------------------------------------------------------
// tb_apb_i2c_csr : directed APB/core stimulus with a queue-based access scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_apb_i2c_csr;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic [31:0] PRDATA;
   logic        PREADY, PSLVERR;
   logic        tx_rd_en = 1'b0;
   logic [7:0]  tx_rd_data;
   logic        tx_empty;
   logic        rx_wr_en = 1'b0;
   logic [7:0]  rx_wr_data = '0;
   logic        rx_full;
   logic        core_error = 1'b0;
   logic [13:0] cfg, timeout;
   logic        INT_TX, INT_RX, INT_ERR;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_rd_q[$];
   logic        exp_err_q[$];
   string       exp_name_q[$];

   apb_i2c_csr #(.FIFO_W(8), .TX_DEPTH(8), .RX_DEPTH(8), .CFG_W(14), .TMO_W(14)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data), .tx_empty(tx_empty),
      .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_full(rx_full),
      .core_error(core_error), .cfg(cfg), .timeout(timeout),
      .INT_TX(INT_TX), .INT_RX(INT_RX), .INT_ERR(INT_ERR)
   );

   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every completed access phase consumes one expectation.
   always @(negedge PCLK) begin
      if (PSELx && PENABLE) begin
         if (exp_err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_access: addr 0x%08h with no expectation queued", PADDR);
         end else begin
            automatic logic [31:0] e_rd  = exp_rd_q.pop_front();
            automatic logic        e_err = exp_err_q.pop_front();
            automatic string       nm    = exp_name_q.pop_front();
            chk({nm, " pready"},  32'(PREADY),  32'h1);
            chk({nm, " pslverr"}, 32'(PSLVERR), 32'(e_err));
            chk({nm, " prdata"},  PRDATA,       e_rd);
         end
      end
   end

   task automatic expect_acc(input logic [31:0] rd, input logic e_err, input string name);
      exp_rd_q.push_back(rd);
      exp_err_q.push_back(e_err);
      exp_name_q.push_back(name);
   endtask

   task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge PCLK); #1;
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic e_err, input string name);
      expect_acc(32'h0, e_err, name);
      apb(1'b1, addr, d);
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] e_rd, input logic e_err, input string name);
      expect_acc(e_err ? 32'h0 : e_rd, e_err, name);
      apb(1'b0, addr, 32'h0);
   endtask

   task automatic core_pop();
      @(posedge PCLK); #1; tx_rd_en = 1'b1;
      @(posedge PCLK); #1; tx_rd_en = 1'b0;
   endtask

   task automatic core_push(input logic [7:0] d);
      @(posedge PCLK); #1; rx_wr_en = 1'b1; rx_wr_data = d;
      @(posedge PCLK); #1; rx_wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;

      // Reset state
      chk("rst tx_empty", 32'(tx_empty), 32'h1);
      chk("rst rx_full",  32'(rx_full),  32'h0);
      chk("rst cfg",      32'(cfg),      32'h0);
      chk("rst timeout",  32'(timeout),  32'h0);
      chk("rst ints",     {29'h0, INT_TX, INT_RX, INT_ERR}, 32'h0);
      rd(32'h08, 32'h0,  1'b0, "rst CONFIG");
      rd(32'h0C, 32'h0,  1'b0, "rst TIMEOUT");
      rd(32'h10, 32'h5,  1'b0, "rst STATUS");
      rd(32'h14, 32'h0,  1'b0, "rst IRQ_EN");
      rd(32'h18, 32'h1,  1'b0, "rst IRQ_STAT");

      // Basic TX path
      wr(32'h00, 32'h5A, 1'b0, "tx push 5A");
      wr(32'h00, 32'hA5, 1'b0, "tx push A5");
      rd(32'h10, 32'h0000_0204, 1'b0, "STATUS tx_lvl2");
      chk("tx head 5A", 32'(tx_rd_data), 32'h5A);
      core_pop();
      chk("tx head A5", 32'(tx_rd_data), 32'hA5);
      chk("tx not empty", 32'(tx_empty), 32'h0);
      core_pop();
      chk("tx empty after 2 pops", 32'(tx_empty), 32'h1);
      core_pop();
      chk("pop on empty ignored", 32'(tx_empty), 32'h1);
      rd(32'h10, 32'h0000_0005, 1'b0, "STATUS tx_lvl0");

      // TX overflow
      wr(32'h14, 32'h04, 1'b0, "IRQ_EN txovf");
      for (int i = 0; i < 9; i++)
         wr(32'h00, 32'h10 + i, (i == 8), $sformatf("tx fill %0d", i));
      rd(32'h10, 32'h0000_0806, 1'b0, "STATUS tx full");
      rd(32'h18, 32'h04, 1'b0, "IRQ_STAT txovf");
      chk("INT_ERR txovf", 32'(INT_ERR), 32'h1);
      wr(32'h18, 32'h04, 1'b0, "W1C txovf");
      rd(32'h18, 32'h00, 1'b0, "IRQ_STAT cleared");
      chk("INT_ERR cleared", 32'(INT_ERR), 32'h0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tx drain %0d", i), 32'(tx_rd_data), 32'h10 + i);
         core_pop();
      end
      chk("tx drained", 32'(tx_empty), 32'h1);

      // RX path and INT_RX latency
      core_push(8'h33);
      wr(32'h14, 32'h02, 1'b0, "IRQ_EN rx");
      chk("INT_RX not yet", 32'(INT_RX), 32'h0);
      @(posedge PCLK); #1;
      chk("INT_RX rises", 32'(INT_RX), 32'h1);
      rd(32'h04, 32'h33, 1'b0, "RXDATA 33");
      rd(32'h04, 32'h0,  1'b1, "RXDATA empty");

      // RX overflow, W1C ignoring level bits, core_error sticky
      for (int i = 0; i < 9; i++) core_push(8'h40 + 8'(i));
      chk("rx_full", 32'(rx_full), 32'h1);
      rd(32'h18, 32'h0B, 1'b0, "IRQ_STAT rxovf");
      rd(32'h04, 32'h40, 1'b0, "RXDATA after ovf");
      wr(32'h18, 32'h1F, 1'b0, "W1C all");
      rd(32'h18, 32'h03, 1'b0, "IRQ_STAT after W1C");
      @(posedge PCLK); #1 core_error = 1'b1;
      @(posedge PCLK); #1 core_error = 1'b0;
      rd(32'h18, 32'h13, 1'b0, "IRQ_STAT core_err");
      wr(32'h14, 32'h10, 1'b0, "IRQ_EN coreerr");
      @(posedge PCLK); #1;
      chk("INT_ERR coreerr", 32'(INT_ERR), 32'h1);

      // Config/timeout width truncation and decode errors
      wr(32'h08, 32'hFFFF_FFFF, 1'b0, "CONFIG all ones");
      chk("cfg truncated", 32'(cfg), 32'h3FFF);
      rd(32'h08, 32'h0000_3FFF, 1'b0, "CONFIG readback");
      wr(32'h0C, 32'h0001_2345, 1'b0, "TIMEOUT write");
      chk("timeout truncated", 32'(timeout), 32'h2345);
      rd(32'h09, 32'h0, 1'b1, "misaligned 0x09");
      wr(32'h1C, 32'h1, 1'b1, "out of range 0x1C");
      rd(32'h00, 32'h0, 1'b1, "read TXDATA");
      wr(32'h10, 32'h0, 1'b1, "write STATUS");
      wr(32'h04, 32'h0, 1'b1, "write RXDATA");
      rd(32'h08, 32'h0000_3FFF, 1'b0, "CONFIG unchanged");

      // Asynchronous reset in the middle of an access
      for (int i = 0; i < 3; i++) wr(32'h00, 32'h60 + i, 1'b0, "pre-reset push");
      chk("tx has data", 32'(tx_empty), 32'h0);
      expect_acc(32'h0, 1'b0, "mid-reset write");
      @(posedge PCLK); #1;
      PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h00; PWDATA = 32'h77;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 PRESETn = 1'b0;
      #1;
      chk("reset tx_empty immediate", 32'(tx_empty), 32'h1);
      chk("reset cfg immediate", 32'(cfg), 32'h0);
      chk("reset INT_ERR", 32'(INT_ERR), 32'h0);
      @(posedge PCLK); #1;
      PSELx = 1'b0; PENABLE = 1'b0;
      PRESETn = 1'b1;
      chk("post-reset tx_rd_data", 32'(tx_rd_data), 32'h0);
      rd(32'h10, 32'h0000_0005, 1'b0, "post-reset STATUS");
      rd(32'h18, 32'h01, 1'b0, "post-reset IRQ_STAT");
      rd(32'h08, 32'h0, 1'b0, "post-reset CONFIG");
      rd(32'h14, 32'h0, 1'b0, "post-reset IRQ_EN");

      for (int i = 0; i < 10 && exp_err_q.size() != 0; i++) @(posedge PCLK);
      chk("scoreboard drained", 32'(exp_err_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
